// File: rtl/cu_pkg.sv
// Shared definitions for the sequential control unit: FSM state encoding,
// opcode values, instruction field offsets and bus-mux source codes.
// The optional LDI instruction is enabled with the CU_LDI_EN macro
// (see seq_control_unit).
package cu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_LOADX = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_XFER  = 3'd4
  } cu_state_e;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_MOV = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  // Low-order instruction fields; register fields sit at the top of the word.
  localparam int OP_LSB  = 0;
  localparam int OP_W    = 2;
  localparam int ALU_LSB = 2;
  localparam int ALU_W   = 3;

  // Bus source code for the G/ALU result (one above the last GP register).
  function automatic int mux_g_code(input int nreg);
    return nreg;
  endfunction

  // Bus source code for the external data input.
  function automatic int mux_din_code(input int nreg);
    return nreg + 1;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational field decoder for the latched instruction register.
module cu_decode
  import cu_pkg::*;
#(
  parameter int NREG = 8,
  parameter int IW   = 16
) (
  input  logic [IW-1:0]             ir_i,
  output logic [$clog2(NREG)-1:0]   rx_o,
  output logic [$clog2(NREG)-1:0]   ry_o,
  output logic [ALU_W-1:0]          alu_o,
  output logic [OP_W-1:0]           op_o,
  output logic                      is_alu_o
);

  localparam int AW = $clog2(NREG);

  assign rx_o     = ir_i[IW-1 -: AW];
  assign ry_o     = ir_i[IW-1-AW -: AW];
  assign alu_o    = ir_i[ALU_LSB +: ALU_W];
  assign op_o     = ir_i[OP_LSB +: OP_W];
  assign is_alu_o = (ir_i[OP_LSB +: OP_W] == OP_ALU);

  // Bits between the register fields and the ALU field carry no meaning.
  if (IW > 2*AW + ALU_LSB + ALU_W) begin : g_spare
    logic unused_spare_s;
    assign unused_spare_s = ^ir_i[IW-1-2*AW : ALU_LSB+ALU_W];
  end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle control FSM for the register-file/ALU datapath.
// ALU ops run FETCH->LOADX->EXEC->WB (4 cycles); MOV/LDI/NOP run
// FETCH->XFER (2 cycles). Every state change needs run=1. Strobes are
// qualified by run, and every output is forced low while rst is high.
// Optional feature macro: CU_LDI_EN (op 10 = load DIN into rx);
// without it op 10 behaves as NOP.
module seq_control_unit
  import cu_pkg::*;
#(
  parameter int NREG  = 8,
  parameter int IW    = 16,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic [IW-1:0]           instr,
  output logic                    en_ir,
  output logic                    en_a,
  output logic                    en_c,
  output logic [$clog2(NREG):0]   mux_sel,
  output logic [2:0]              alu_sel,
  output logic [NREG-1:0]         reg_en,
  output logic                    done,
  output logic                    busy,
  output logic [CNT_W-1:0]        instr_cnt
);

  localparam int AW = $clog2(NREG);
  localparam int MW = AW + 1;
  localparam logic [MW-1:0]   MUX_G     = MW'(mux_g_code(NREG));
`ifdef CU_LDI_EN
  localparam logic [MW-1:0]   MUX_DIN   = MW'(mux_din_code(NREG));
`endif
  localparam logic [NREG-1:0] ONE_HOT_0 = {{(NREG-1){1'b0}}, 1'b1};

  cu_state_e         state_q;
  logic [IW-1:0]     ir_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic [AW-1:0]     rx_s;
  logic [AW-1:0]     ry_s;
  logic [ALU_W-1:0]  alu_s;
  logic [OP_W-1:0]   op_s;
  logic              is_alu_s;

  // Per-state controls before run/reset qualification.
  logic              ir_raw_s;
  logic              a_raw_s;
  logic              c_raw_s;
  logic              done_raw_s;
  logic [NREG-1:0]   wr_raw_s;
  logic [MW-1:0]     mux_raw_s;
  logic [2:0]        alu_raw_s;

  logic              live_s;
  logic              strobe_s;

  assign live_s   = ~rst;
  assign strobe_s = run & ~rst;

  cu_decode #(
    .NREG (NREG),
    .IW   (IW)
  ) u_decode (
    .ir_i     (ir_q),
    .rx_o     (rx_s),
    .ry_o     (ry_s),
    .alu_o    (alu_s),
    .op_o     (op_s),
    .is_alu_o (is_alu_s)
  );

  // Datapath controls implied by the current state and latched instruction.
  always_comb begin
    ir_raw_s   = 1'b0;
    a_raw_s    = 1'b0;
    c_raw_s    = 1'b0;
    done_raw_s = 1'b0;
    wr_raw_s   = {NREG{1'b0}};
    mux_raw_s  = {MW{1'b0}};
    alu_raw_s  = 3'b000;
    case (state_q)
      ST_FETCH: begin
        ir_raw_s = 1'b1;
      end
      ST_LOADX: begin
        a_raw_s   = is_alu_s;
        mux_raw_s = {1'b0, rx_s};
      end
      ST_EXEC: begin
        c_raw_s   = is_alu_s;
        mux_raw_s = {1'b0, ry_s};
        alu_raw_s = alu_s;
      end
      ST_WB: begin
        // The write is qualified by the decoded opcode so a corrupted ir
        // cannot produce a register write; the instruction still retires.
        mux_raw_s  = MUX_G;
        wr_raw_s   = is_alu_s ? (ONE_HOT_0 << rx_s) : {NREG{1'b0}};
        done_raw_s = 1'b1;
      end
      ST_XFER: begin
        done_raw_s = 1'b1;
        case (op_s)
          OP_MOV: begin
            mux_raw_s = {1'b0, ry_s};
            wr_raw_s  = ONE_HOT_0 << rx_s;
          end
`ifdef CU_LDI_EN
          OP_LDI: begin
            mux_raw_s = MUX_DIN;
            wr_raw_s  = ONE_HOT_0 << rx_s;
          end
`endif
          OP_NOP: begin
            wr_raw_s = {NREG{1'b0}};
          end
          default: begin
            wr_raw_s = {NREG{1'b0}};
          end
        endcase
      end
      default: begin
        wr_raw_s = {NREG{1'b0}};
      end
    endcase
  end

  assign en_ir     = ir_raw_s & strobe_s;
  assign en_a      = a_raw_s & strobe_s;
  assign en_c      = c_raw_s & strobe_s;
  assign done      = done_raw_s & strobe_s;
  assign reg_en    = wr_raw_s & {NREG{strobe_s}};
  assign mux_sel   = mux_raw_s & {MW{live_s}};
  assign alu_sel   = alu_raw_s & {3{live_s}};
  assign busy      = (state_q != ST_FETCH) & live_s;
  assign instr_cnt = cnt_q & {CNT_W{live_s}};

  // Retired-instruction count advances on each qualified done pulse.
  always_comb begin
    if (done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Sequencer: state, instruction register and counter; all hold when run=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      ir_q    <= {IW{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else if (run) begin
      cnt_q <= cnt_d;
      case (state_q)
        ST_FETCH: begin
          ir_q    <= instr;
          // Branch on the live word; ir only becomes valid next cycle.
          state_q <= (instr[OP_LSB +: OP_W] == OP_ALU) ? ST_LOADX : ST_XFER;
        end
        ST_LOADX: state_q <= ST_EXEC;
        ST_EXEC:  state_q <= ST_WB;
        ST_WB:    state_q <= ST_FETCH;
        ST_XFER:  state_q <= ST_FETCH;
        default:  state_q <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_control_unit.sv
// Self-checking bench for seq_control_unit (NREG=8, IW=16, CNT_W=4).
// The reference model tracks each instruction as a position within its
// micro-step sequence (length 4 for ALU ops, 2 otherwise) and derives the
// expected outputs from the instruction fields directly.
module tb_seq_control_unit;

  localparam int NREG  = 8;
  localparam int IW    = 16;
  localparam int CNT_W = 4;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        run   = 1'b0;
  logic [15:0] instr = 16'h0000;

  logic        en_ir, en_a, en_c, done, busy;
  logic [3:0]  mux_sel;
  logic [2:0]  alu_sel;
  logic [7:0]  reg_en;
  logic [3:0]  instr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [15:0] m_ir   = 16'h0000;
  int          m_step = 0;
  int          m_cnt  = 0;

  // Outputs observed in the most recent step, for literal checks.
  logic        o_en_ir, o_en_a, o_en_c, o_done, o_busy;
  logic [3:0]  o_mux;
  logic [2:0]  o_alu;
  logic [7:0]  o_reg;
  logic [3:0]  o_cnt;

  seq_control_unit #(
    .NREG  (NREG),
    .IW    (IW),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .instr     (instr),
    .en_ir     (en_ir),
    .en_a      (en_a),
    .en_c      (en_c),
    .mux_sel   (mux_sel),
    .alu_sel   (alu_sel),
    .reg_en    (reg_en),
    .done      (done),
    .busy      (busy),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int seq_len(input logic [15:0] w);
    return (w[1:0] == 2'b00) ? 4 : 2;
  endfunction

  // Drive one cycle, compare every output against the model, advance model.
  task automatic step(input logic r, input logic rn, input logic [15:0] ins);
    logic       e_ir, e_a, e_c, e_done, e_busy;
    logic [3:0] e_mux;
    logic [2:0] e_alu;
    logic [7:0] e_reg;
    logic [3:0] e_cnt;
    logic [2:0] rx, ry;
    logic [1:0] op;
    @(negedge clk);
    rst   = r;
    run   = rn;
    instr = ins;
    #1;
    e_ir = 1'b0; e_a = 1'b0; e_c = 1'b0; e_done = 1'b0; e_busy = 1'b0;
    e_mux = 4'd0; e_alu = 3'd0; e_reg = 8'h00;
    e_cnt = 4'(m_cnt);
    rx = m_ir[15:13];
    ry = m_ir[12:10];
    op = m_ir[1:0];
    if (r) begin
      e_cnt = 4'd0;
    end else if (m_step == 0) begin
      e_ir = rn;
    end else begin
      e_busy = 1'b1;
      if (op == 2'b00) begin
        if (m_step == 1) begin
          e_a = rn; e_mux = {1'b0, rx};
        end else if (m_step == 2) begin
          e_c = rn; e_mux = {1'b0, ry}; e_alu = m_ir[4:2];
        end else begin
          e_mux = 4'(NREG); e_done = rn;
          e_reg = rn ? (8'd1 << rx) : 8'h00;
        end
      end else begin
        e_done = rn;
        if (op == 2'b01) begin
          e_mux = {1'b0, ry};
          e_reg = rn ? (8'd1 << rx) : 8'h00;
        end
`ifdef CU_LDI_EN
        if (op == 2'b10) begin
          e_mux = 4'(NREG + 1);
          e_reg = rn ? (8'd1 << rx) : 8'h00;
        end
`endif
      end
    end
    check("en_ir",     32'(en_ir),     32'(e_ir));
    check("en_a",      32'(en_a),      32'(e_a));
    check("en_c",      32'(en_c),      32'(e_c));
    check("mux_sel",   32'(mux_sel),   32'(e_mux));
    check("alu_sel",   32'(alu_sel),   32'(e_alu));
    check("reg_en",    32'(reg_en),    32'(e_reg));
    check("done",      32'(done),      32'(e_done));
    check("busy",      32'(busy),      32'(e_busy));
    check("instr_cnt", 32'(instr_cnt), 32'(e_cnt));
    o_en_ir = en_ir; o_en_a = en_a; o_en_c = en_c; o_done = done; o_busy = busy;
    o_mux = mux_sel; o_alu = alu_sel; o_reg = reg_en; o_cnt = instr_cnt;
    if (r) begin
      m_step = 0; m_ir = 16'h0000; m_cnt = 0;
    end else if (rn) begin
      if (m_step == 0) begin
        m_ir = ins; m_step = 1;
      end else if (m_step == seq_len(m_ir) - 1) begin
        m_step = 0; m_cnt = (m_cnt + 1) % 16;
      end else begin
        m_step++;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    // Reset state.
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 16'h7408);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_cnt",  32'(o_cnt),  32'd0);

    // ALU rx3 ry5 alu2: four cycles.
    step(1'b0, 1'b1, 16'h7408);
    check("alu_c1_en_ir", 32'(o_en_ir), 32'd1);
    step(1'b0, 1'b1, 16'h0000);
    check("alu_c2_en_a", 32'(o_en_a), 32'd1);
    check("alu_c2_mux",  32'(o_mux),  32'd3);
    step(1'b0, 1'b1, 16'h0000);
    check("alu_c3_en_c", 32'(o_en_c), 32'd1);
    check("alu_c3_mux",  32'(o_mux),  32'd5);
    check("alu_c3_alu",  32'(o_alu),  32'd2);
    step(1'b0, 1'b1, 16'h0000);
    check("alu_c4_reg",  32'(o_reg),  32'h08);
    check("alu_c4_mux",  32'(o_mux),  32'd8);
    check("alu_c4_done", 32'(o_done), 32'd1);

    // MOV rx1 ry6: two cycles.
    step(1'b0, 1'b1, 16'h3801);
    check("mov_cnt1",  32'(o_cnt),  32'd1);
    check("mov_busy0", 32'(o_busy), 32'd0);
    step(1'b0, 1'b1, 16'h0000);
    check("mov_reg",   32'(o_reg),  32'h02);
    check("mov_mux",   32'(o_mux),  32'd6);
    check("mov_busy1", 32'(o_busy), 32'd1);

    // Stall three cycles in EXEC with a changing instr.
    step(1'b0, 1'b1, 16'h7408);
    step(1'b0, 1'b1, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'($urandom));
      check("stall_en_c", 32'(o_en_c), 32'd0);
      check("stall_mux",  32'(o_mux),  32'd5);
    end
    step(1'b0, 1'b1, 16'h1C01);
    check("stall_resume_en_c", 32'(o_en_c), 32'd1);
    step(1'b0, 1'b1, 16'hFFFF);
    check("stall_wb_reg", 32'(o_reg), 32'h08);

    // Reset during LOADX aborts the instruction.
    step(1'b0, 1'b1, 16'h2000);
    step(1'b1, 1'b1, 16'h2000);
    check("abort_en_a", 32'(o_en_a), 32'd0);
    step(1'b0, 1'b1, 16'h0003);
    check("abort_fetch", 32'(o_en_ir), 32'd1);
    check("abort_cnt",   32'(o_cnt),   32'd0);
    step(1'b0, 1'b1, 16'h0000);

    // Op 10 with rx7.
    step(1'b0, 1'b1, 16'hE002);
    step(1'b0, 1'b1, 16'h0000);
    check("ldi_done", 32'(o_done), 32'd1);
`ifdef CU_LDI_EN
    check("ldi_reg", 32'(o_reg), 32'h80);
    check("ldi_mux", 32'(o_mux), 32'd9);
`else
    check("ldi_reg", 32'(o_reg), 32'h00);
    check("ldi_mux", 32'(o_mux), 32'd0);
`endif

    // Counter wrap with 17 NOPs.
    step(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 16'h0003);
      if (i == 15) check("wrap_cnt15", 32'(o_cnt), 32'd15);
      if (i == 16) check("wrap_cnt0",  32'(o_cnt), 32'd0);
      step(1'b0, 1'b1, 16'h0003);
    end
    step(1'b0, 1'b0, 16'h0000);
    check("wrap_cnt1", 32'(o_cnt), 32'd1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
